alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer sharing one multi-cycle `alu` instance between two command sources. It accepts operand/opcode commands from requester 0 and requester 1 with round-robin fairness. It drives the ALU start/operand pins, waits for `done`, and returns the registered result and status flags tagged with the requester id. It sits between the board-level control logic (switch/button front end, or a future command sequencer) and the `alu` datapath.

## Interface
Parameters:
- `WIDTH`, 8: operand width; result is `2*WIDTH`.
- `TIMEOUT`, 64: maximum WAIT cycles before abort; used only with `ALU_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  command request, held until matching ack.
- `a0`, `b0` / `a1`, `b1`  in  WIDTH  operands, stable while req high.
- `op0` / `op1`  in  2  ALU opcode.
- `ack0` / `ack1`  out  1  one-cycle pulse: command captured.
- `alu_start`  out  1  one-cycle start pulse to ALU.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to ALU.
- `alu_op`  out  2  registered opcode to ALU.
- `alu_result`  in  2*WIDTH  ALU result.
- `alu_done`, `alu_overflow`, `alu_div_by_zero`, `alu_zero`  in  1  ALU status.
- `rsp_valid`  out  1  one-cycle pulse: response valid.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_result`  out  2*WIDTH  captured result.
- `rsp_flags`  out  3  {overflow, div_by_zero, zero}.
- `rsp_timeout`  out  1  response was a timeout abort.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE: if any req is high, select a winner and register its a/b/op into `alu_a/alu_b/alu_op`. Also capture `rsp_id`, then go to ISSUE.
- Winner selection: a single requester always wins. On a tie, the requester favored by a 1-bit pointer wins.
- Pointer behaviour: the pointer resets to 0. In RESP it is set to the non-served requester.
- ISSUE: `ackN` pulses for the winner and `alu_start`=1 for this cycle only. Go to WAIT.
- WAIT: `alu_done`=1 captures `alu_result` and the three flags, then go to RESP. `alu_done` is sampled only in WAIT and ignored in all other states, including the ISSUE cycle.
- RESP: `rsp_valid`=1 for one cycle with `rsp_id`, `rsp_result` and `rsp_flags`. Go to IDLE.
- `alu_a/alu_b/alu_op` hold their values from capture until the next capture.
- `rsp_*` data holds until the next RESP; only `rsp_valid` pulses.
- A requester that keeps req high after its ack is treated as issuing a new command.
- Reset values: every output is 0, state is IDLE and the pointer is 0.
- Reset mid-operation: any in-flight command is dropped with no response and no ack. A stale `alu_done` arriving after reset is ignored.
- ALU reset wiring: the integrator drives the ALU's `rst_n` from `~rst`.

## Timing
- Cycle T: IDLE, request sampled.
- Cycle T+1: ISSUE, ack pulse and `alu_start` pulse.
- Cycle D: `alu_done` sampled high in WAIT.
- Cycle D+1: RESP, `rsp_valid`.
- Cycle D+2: IDLE, next request can be sampled.
- Minimum command-to-response latency: 3 cycles plus ALU latency.
- Maximum throughput: one command per (ALU latency + 3) cycles.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT` without `alu_done`, go to RESP with `rsp_timeout`=1, `rsp_result`=0 and `rsp_flags`=0.
  - `alu_done` arriving on the same cycle as expiry wins: normal response, `rsp_timeout`=0.
- `ALU_ARB_TIMEOUT_EN` undefined: WAIT waits indefinitely, `rsp_timeout` is tied 0, and `TIMEOUT` is unused.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - the 2-bit opcode localparams shared with `alu`;
  - the FSM state encoding;
  - the `rsp_flags` bit indices (OVF=2, DBZ=1, ZERO=0).
- One sub-module: `alu_arb_rr`, a combinational 2-way round-robin pick (inputs: req pair and pointer; outputs: grant vector and winner id).
- FSM, capture registers and timeout counter stay in `alu_arbiter`.

## Test plan
- req0 only, a0=8'h12, b0=8'h34, op0=add, ALU done 4 cycles after start:
  - ack0 at T+1;
  - `alu_start` at T+1 with alu_a=8'h12;
  - `rsp_valid` with rsp_id=0, rsp_result=16'h0046, flags=3'b000.
- req0 and req1 asserted simultaneously from reset, both held after ack:
  - grant order is 0, 1, 0, 1;
  - each rsp_id matches its ack.
- req1 with b1=0, op1=div, ALU returns div_by_zero=1: `rsp_flags`=3'b010, rsp_id=1.
- `rst` pulsed during WAIT, then a late `alu_done` arrives:
  - all outputs return to 0 the cycle after reset;
  - no `rsp_valid`;
  - next req0 is served normally.
- With `ALU_ARB_TIMEOUT_EN`, TIMEOUT=8, ALU never asserts done:
  - `rsp_valid` with `rsp_timeout`=1 and result 0, 8 cycles after WAIT entry.
- With `ALU_ARB_TIMEOUT_EN`, `alu_done` on the expiry cycle: normal response with `rsp_timeout`=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// =====================================================================
// Module  : alu_ctrl_pkg
// Purpose : Opcodes, arbiter FSM encoding and response flag bit indices
// Revision: 1.0 - initial release
// =====================================================================
package alu_ctrl_pkg;

    // Opcode values shared with the alu datapath
    localparam logic [1:0] c_op_add = 2'd0;
    localparam logic [1:0] c_op_sub = 2'd1;
    localparam logic [1:0] c_op_mul = 2'd2;
    localparam logic [1:0] c_op_div = 2'd3;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    localparam int c_flag_ovf  = 2;
    localparam int c_flag_dbz  = 1;
    localparam int c_flag_zero = 0;

endpackage
`default_nettype wire

// File: rtl/alu_arb_rr.sv
`default_nettype none
// =====================================================================
// Module  : alu_arb_rr
// Purpose : Combinational 2-way round-robin pick (grant vector + winner id)
// Revision: 1.0 - initial release
// =====================================================================
module alu_arb_rr
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_grant,
    output logic       o_winner
);

    always_comb begin
        o_winner = 1'b0;
        o_grant  = 2'b00;
        case (i_req)
            2'b01:   o_winner = 1'b0;
            2'b10:   o_winner = 1'b1;
            2'b11:   o_winner = i_ptr;   // tie goes to the favored requester
            default: o_winner = 1'b0;
        endcase
        if (i_req != 2'b00) begin
            o_grant = o_winner ? 2'b10 : 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// =====================================================================
// Module  : alu_arbiter
// Purpose : Round-robin arbiter/sequencer sharing one multi-cycle alu.
//           Optional WAIT abort enabled by defining ALU_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// =====================================================================
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [1:0]           op0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    input  logic [1:0]           op1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 alu_start,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [1:0]           alu_op,
    input  logic [2*WIDTH-1:0]   alu_result,
    input  logic                 alu_done,
    input  logic                 alu_overflow,
    input  logic                 alu_div_by_zero,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_result,
    output logic [2:0]           rsp_flags,
    output logic                 rsp_timeout,
    output logic                 busy
);

    logic [1:0]         r_state;
    logic               r_ptr;
    logic               r_owner;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [1:0]         r_alu_op;
    logic               r_rsp_id;
    logic [2*WIDTH-1:0] r_rsp_result;
    logic [2:0]         r_rsp_flags;
    logic               r_rsp_timeout;

    logic [1:0]         w_grant;
    logic               w_winner;
    logic               w_expire;

    alu_arb_rr u_rr (
        .i_req    ({req1, req0}),
        .i_ptr    (r_ptr),
        .o_grant  (w_grant),
        .o_winner (w_winner)
    );

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [c_cnt_w-1:0] r_wait_cnt;

    // Cleared while in ISSUE so the first WAIT cycle counts as zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == c_st_issue) begin
            r_wait_cnt <= '0;
        end else if (r_state == c_st_wait) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_expire = (r_state == c_st_wait) && (r_wait_cnt == c_cnt_w'(TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_expire         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_ptr         <= 1'b0;
            r_owner       <= 1'b0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_op      <= '0;
            r_rsp_id      <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_flags   <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req0 || req1) begin
                        r_owner  <= w_winner;
                        r_alu_a  <= ({WIDTH{w_grant[0]}} & a0)  | ({WIDTH{w_grant[1]}} & a1);
                        r_alu_b  <= ({WIDTH{w_grant[0]}} & b0)  | ({WIDTH{w_grant[1]}} & b1);
                        r_alu_op <= ({2{w_grant[0]}} & op0) | ({2{w_grant[1]}} & op1);
                        r_state  <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    // done beats a simultaneous expiry
                    if (alu_done) begin
                        r_rsp_id                  <= r_owner;
                        r_rsp_result              <= alu_result;
                        r_rsp_flags[c_flag_ovf]   <= alu_overflow;
                        r_rsp_flags[c_flag_dbz]   <= alu_div_by_zero;
                        r_rsp_flags[c_flag_zero]  <= alu_zero;
                        r_rsp_timeout             <= 1'b0;
                        r_state                   <= c_st_resp;
                    end else if (w_expire) begin
                        r_rsp_id      <= r_owner;
                        r_rsp_result  <= '0;
                        r_rsp_flags   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= c_st_resp;
                    end
                end
                c_st_resp: begin
                    r_ptr   <= ~r_owner;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign ack0        = (r_state == c_st_issue) && !r_owner;
    assign ack1        = (r_state == c_st_issue) &&  r_owner;
    assign alu_start   = (r_state == c_st_issue);
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;
    assign rsp_valid   = (r_state == c_st_resp);
    assign rsp_id      = r_rsp_id;
    assign rsp_result  = r_rsp_result;
    assign rsp_flags   = r_rsp_flags;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// =====================================================================
// Module  : tb_alu_arbiter
// Purpose : Self-checking bench: vector table, behavioural alu, scoreboard
// Revision: 1.0 - initial release
// =====================================================================
module tb_alu_arbiter;
    import alu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]  op0 = '0, op1 = '0;
    logic        ack0, ack1, alu_start;
    logic [7:0]  alu_a, alu_b;
    logic [1:0]  alu_op;
    logic [15:0] alu_result = '0;
    logic        alu_done = 1'b0, alu_overflow = 1'b0, alu_div_by_zero = 1'b0, alu_zero = 1'b0;
    logic        rsp_valid, rsp_id, rsp_timeout, busy;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_flags;

    alu_arbiter #(.WIDTH(8), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .op0(op0),
        .req1(req1), .a1(a1), .b1(b1), .op1(op1),
        .ack0(ack0), .ack1(ack1),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_done(alu_done), .alu_overflow(alu_overflow),
        .alu_div_by_zero(alu_div_by_zero), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural alu: done arrives alu_lat cycles after start (0 = never)
    int   alu_lat = 4;
    int   alu_cnt = 0;
    logic inject_done = 1'b0;

    function automatic logic [18:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [1:0] op);
        logic [15:0] r;
        logic        ovf;
        logic        dbz;
        ovf = 1'b0;
        dbz = 1'b0;
        case (op)
            c_op_add: r = {8'h00, a} + {8'h00, b};
            c_op_sub: begin r = {8'h00, a} - {8'h00, b}; ovf = (a < b); end
            c_op_mul: r = {8'h00, a} * {8'h00, b};
            default: begin
                if (b == 8'h00) begin r = 16'h0000; dbz = 1'b1; end
                else r = {8'h00, a} / {8'h00, b};
            end
        endcase
        return {ovf, dbz, (!dbz && r == 16'h0000), r};
    endfunction

    always @(posedge clk) begin
        alu_done <= inject_done;
        if (rst) begin
            alu_cnt <= 0;
        end else if (alu_start) begin
            {alu_overflow, alu_div_by_zero, alu_zero, alu_result} <= alu_model(alu_a, alu_b, alu_op);
            if (alu_lat == 1) alu_done <= 1'b1;
            alu_cnt <= (alu_lat > 1) ? alu_lat - 1 : 0;
        end else if (alu_cnt > 0) begin
            alu_cnt <= alu_cnt - 1;
            if (alu_cnt == 1) alu_done <= 1'b1;
        end
    end

    typedef struct {
        logic        id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  op;
        int          lat;
        logic [15:0] res;
        logic [2:0]  flags;
        logic        tmo;
    } vec_t;

    typedef struct {
        logic        id;
        logic [15:0] res;
        logic [2:0]  flags;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_ack(output int cyc, output logic [1:0] acks);
        cyc  = 0;
        acks = 2'b00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (ack0 || ack1) begin
                acks = {ack1, ack0};
                break;
            end
        end
    endtask

    task automatic wait_rsp(output int cyc);
        exp_t e;
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rsp_seen", seen, 1'b1);
        if (seen) begin
            chk("sb_nonempty", (sb.size() > 0), 1'b1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_flags", rsp_flags, e.flags);
                chk("rsp_timeout", rsp_timeout, e.tmo);
            end
            @(negedge clk);
            chk("rsp_pulse_idle", {rsp_valid, busy}, 2'b00);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle
    task automatic run_cmd(input vec_t v, input int exp_rsp_lat);
        int         cyc;
        int         rcyc;
        logic [1:0] acks;
        alu_lat = v.lat;
        if (v.id) begin
            req1 = 1'b1; a1 = v.a;  b1 = v.b;  op1 = v.op;
            a0   = ~v.a; b0 = ~v.b; op0 = ~v.op;
        end else begin
            req0 = 1'b1; a0 = v.a;  b0 = v.b;  op0 = v.op;
            a1   = ~v.a; b1 = ~v.b; op1 = ~v.op;
        end
        wait_ack(cyc, acks);
        chk("ack_latency", cyc, 1);
        chk("ack_vec", acks, v.id ? 2'b10 : 2'b01);
        chk("alu_start", alu_start, 1'b1);
        chk("alu_operands", {alu_a, alu_b, alu_op}, {v.a, v.b, v.op});
        sb.push_back('{v.id, v.res, v.flags, v.tmo});
        req0 = 1'b0;
        req1 = 1'b0;
        wait_rsp(rcyc);
        chk("rsp_latency", rcyc, exp_rsp_lat);
    endtask

    function automatic logic [43:0] all_outputs();
        return {ack0, ack1, alu_start, alu_a, alu_b, alu_op, rsp_valid, rsp_id,
                rsp_result, rsp_flags, rsp_timeout, busy};
    endfunction

    vec_t vt[7];

    initial begin
        int         cyc;
        int         seen;
        logic [1:0] acks;
        exp_t       pend[2];
        vec_t       v;

        vt[0] = '{1'b0, 8'h12, 8'h34, c_op_add, 4, 16'h0046, 3'b000, 1'b0};
        vt[1] = '{1'b1, 8'h07, 8'h00, c_op_div, 3, 16'h0000, 3'b010, 1'b0};
        vt[2] = '{1'b0, 8'hff, 8'hff, c_op_mul, 2, 16'hfe01, 3'b000, 1'b0};
        vt[3] = '{1'b1, 8'h05, 8'h05, c_op_sub, 1, 16'h0000, 3'b001, 1'b0};
        vt[4] = '{1'b0, 8'h03, 8'h05, c_op_sub, 5, 16'hfffe, 3'b100, 1'b0};
        vt[5] = '{1'b1, 8'hc8, 8'h64, c_op_add, 3, 16'h012c, 3'b000, 1'b0};
        vt[6] = '{1'b0, 8'h64, 8'h07, c_op_div, 2, 16'h000e, 3'b000, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outputs(), 44'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_cmd(vt[i], vt[i].lat + 1);
        end

        // Reset during WAIT, followed by a stale done
        alu_lat = 0;
        req0 = 1'b1; a0 = 8'h21; b0 = 8'h02; op0 = c_op_add;
        wait_ack(cyc, acks);
        chk("rst_seq_ack", acks, 2'b01);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_seq_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", all_outputs(), 44'h0);
        rst = 1'b0;
        inject_done = 1'b1;
        @(negedge clk);
        inject_done = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        chk("stale_done_ignored", seen, 0);
        run_cmd(vt[0], vt[0].lat + 1);

        // Simultaneous held requests from reset alternate 0,1,0,1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        alu_lat = 2;
        pend[0] = '{1'b0, 16'h000d, 3'b000, 1'b0};
        pend[1] = '{1'b1, 16'h0024, 3'b000, 1'b0};
        req0 = 1'b1; a0 = 8'h0a; b0 = 8'h03; op0 = c_op_add;
        req1 = 1'b1; a1 = 8'h09; b1 = 8'h04; op1 = c_op_mul;
        for (int k = 0; k < 4; k++) begin
            wait_ack(cyc, acks);
            chk("rr_order", acks, (k % 2 == 1) ? 2'b10 : 2'b01);
            sb.push_back(pend[acks[1]]);
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            wait_rsp(cyc);
        end

`ifdef ALU_ARB_TIMEOUT_EN
        v = '{1'b1, 8'h11, 8'h22, c_op_add, 0, 16'h0000, 3'b000, 1'b1};
        run_cmd(v, 9);
        v = '{1'b0, 8'h12, 8'h34, c_op_add, 8, 16'h0046, 3'b000, 1'b0};
        run_cmd(v, 9);
`else
        v = vt[5];
        run_cmd(v, v.lat + 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
